// File: rtl/gpio_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// gpio_ctrl_pkg
//   Shared types and helpers for the GPIO bank input/interrupt engine.
//   - gpio_intr_mode_e : per-pin event detection mode (2 bits per pin in CSR)
//   - gpio_event()     : evaluates one pin's event from its filtered value and
//                        the same value delayed by one cycle
// -----------------------------------------------------------------------------
package gpio_ctrl_pkg;

    typedef enum logic [1:0] {
        GPIO_INTR_RISE       = 2'b00,
        GPIO_INTR_FALL       = 2'b01,
        GPIO_INTR_BOTH       = 2'b10,
        GPIO_INTR_LEVEL_HIGH = 2'b11
    } gpio_intr_mode_e;

    // Event for one pin. Only the filtered value and its one-cycle delay are
    // looked at, so reprogramming the mode can never fabricate an edge.
    function automatic logic gpio_event(input gpio_intr_mode_e mode,
                                        input logic            f,
                                        input logic            f_q);
        logic hit;
        hit = 1'b0;
        case (mode)
            GPIO_INTR_RISE:       hit = f & ~f_q;
            GPIO_INTR_FALL:       hit = ~f & f_q;
            GPIO_INTR_BOTH:       hit = f ^ f_q;
            GPIO_INTR_LEVEL_HIGH: hit = f;
            default:              hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/gpio_ctrl_intr_engine_if.sv
// -----------------------------------------------------------------------------
// gpio_ctrl_intr_engine_if
//   CSR-side bundle between a bank's register block and its input/interrupt
//   engine.
//   master (CSR block) drives:
//     cfg_mode[2*NUM_PINS]       per-pin gpio_intr_mode_e, pin i at [2i+:2]
//     cfg_debounce_en[NUM_PINS]  1 = debounce pin i
//     cfg_debounce_limit[DEB_W]  ticks of disagreement before a change is taken
//     cfg_prescale[PRESC_W]      tick period = cfg_prescale+1 clk cycles
//     intr_enable[NUM_PINS]      per-pin interrupt mask
//     status_clr[NUM_PINS]       W1C clear pulses
//   slave (engine) drives:
//     filtered_data[NUM_PINS]    synchronised, debounced pin values
//     status[NUM_PINS]           latched event status
// -----------------------------------------------------------------------------
interface gpio_ctrl_intr_engine_if #(
    parameter int NUM_PINS = 32,
    parameter int DEB_W    = 8,
    parameter int PRESC_W  = 16
);
    logic [2*NUM_PINS-1:0] cfg_mode;
    logic [NUM_PINS-1:0]   cfg_debounce_en;
    logic [DEB_W-1:0]      cfg_debounce_limit;
    logic [PRESC_W-1:0]    cfg_prescale;
    logic [NUM_PINS-1:0]   intr_enable;
    logic [NUM_PINS-1:0]   status_clr;
    logic [NUM_PINS-1:0]   filtered_data;
    logic [NUM_PINS-1:0]   status;

    modport master (
        output cfg_mode, cfg_debounce_en, cfg_debounce_limit, cfg_prescale,
               intr_enable, status_clr,
        input  filtered_data, status
    );

    modport slave (
        input  cfg_mode, cfg_debounce_en, cfg_debounce_limit, cfg_prescale,
               intr_enable, status_clr,
        output filtered_data, status
    );
endinterface

// File: rtl/gpio_ctrl_cdc_sync.sv
// -----------------------------------------------------------------------------
// gpio_ctrl_cdc_sync
//   Multi-flop synchroniser for WIDTH independent asynchronous bits. Each bit is
//   synchronised on its own; no cross-bit coherency is implied.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     d[WIDTH]     asynchronous inputs
//     q[WIDTH]     synchronised outputs, STAGES cycles after capture
// -----------------------------------------------------------------------------
module gpio_ctrl_cdc_sync #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // chain[0] is the metastability-catching stage, chain[STAGES-1] the output.
    logic [STAGES-1:0][WIDTH-1:0] chain;

    // NOTE: sequential state uses <= so every flop samples the pre-edge value
    //       of its neighbour; blocking = here would collapse the chain.
    // NOTE: this is a handful of flops, not a RAM, so it is reset; pins then
    //       read 0 until real samples have propagated through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/gpio_ctrl_debounce.sv
// -----------------------------------------------------------------------------
// gpio_ctrl_debounce
//   Single-pin debounce filter. While enabled, the filtered value only follows
//   the synchronised input after it has disagreed for limit+1 consecutive
//   ticks; any cycle of agreement restarts the count. While disabled the
//   filter is transparent (one register stage).
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     sync_in      synchronised pin value
//     tick         shared prescaled tick, one clk wide
//     en           1 = filter, 0 = pass-through
//     limit[DEB_W] ticks of disagreement tolerated before a change is taken
//     filt         filtered pin value
// -----------------------------------------------------------------------------
module gpio_ctrl_debounce #(
    parameter int DEB_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync_in,
    input  logic             tick,
    input  logic             en,
    input  logic [DEB_W-1:0] limit,
    output logic             filt
);

    logic [DEB_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt <= 1'b0;
            cnt  <= '0;
        end else if (!en) begin
            filt <= sync_in;
            cnt  <= '0;
        end else if (sync_in == filt) begin
            cnt <= '0;
        end else if (tick) begin
            // >= rather than == so a limit lowered mid-count still releases
            // the change; the increment only happens below limit, so the
            // counter can never wrap.
            if (cnt >= limit) begin
                filt <= sync_in;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpio_ctrl_intr_engine.sv
// -----------------------------------------------------------------------------
// gpio_ctrl_intr_engine
//   Per-bank GPIO input conditioning and interrupt engine:
//     raw pins -> synchroniser -> optional debounce -> event detect ->
//     W1C status -> registered interrupt.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     gpio_in[NUM_PINS]   raw asynchronous pins
//     csr (slave)         config, clear pulses, filtered_data and status
//     interrupt           registered |(status & intr_enable)
// -----------------------------------------------------------------------------
module gpio_ctrl_intr_engine
    import gpio_ctrl_pkg::*;
#(
    parameter int NUM_PINS    = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 8,
    parameter int PRESC_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_PINS-1:0]   gpio_in,
    gpio_ctrl_intr_engine_if.slave csr,
    output logic                  interrupt
);

    // Events are held off until a pin level present at reset release has
    // travelled through sync, filter and the f/f_q pair, so pins that are
    // already high never look like a fresh RISE.
    localparam int ARM_CYCLES = SYNC_STAGES + 2;
    localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

    logic [NUM_PINS-1:0] sync_pins;
    logic [NUM_PINS-1:0] filt;
    logic [NUM_PINS-1:0] filt_q;
    logic [NUM_PINS-1:0] evt;
    logic [NUM_PINS-1:0] status_q;
    logic [PRESC_W-1:0]  presc_cnt;
    logic                tick;
    logic [ARM_W-1:0]    arm_cnt;
    logic                armed;

    // ---------------------------------------------------------------- sync
    gpio_ctrl_cdc_sync #(
        .WIDTH  (NUM_PINS),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (gpio_in),
        .q     (sync_pins)
    );

    // ----------------------------------------------------------- prescaler
    // Compare with >= so that lowering cfg_prescale below the running count
    // fires a tick on the next cycle instead of waiting for a full wrap.
    assign tick = (presc_cnt >= csr.cfg_prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------ debounce
    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
        gpio_ctrl_debounce #(
            .DEB_W (DEB_W)
        ) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .sync_in (sync_pins[i]),
            .tick    (tick),
            .en      (csr.cfg_debounce_en[i]),
            .limit   (csr.cfg_debounce_limit),
            .filt    (filt[i])
        );
    end

    // ----------------------------------------------------------------- arm
    assign armed = (arm_cnt == ARM_W'(ARM_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_cnt <= '0;
        end else if (!armed) begin
            arm_cnt <= arm_cnt + 1'b1;
        end
    end

    // --------------------------------------------------------------- event
    // NOTE: evt is given a value before the loop so every path assigns it;
    //       leaving any path unassigned in always_comb would infer a latch.
    always_comb begin
        evt = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            evt[i] = gpio_event(gpio_intr_mode_e'(csr.cfg_mode[2*i +: 2]),
                                filt[i], filt_q[i]);
        end
    end

    // ------------------------------------------------- status and interrupt
    // Set has priority over clear: an event in the same cycle as its W1C
    // pulse must not be lost. intr_enable only gates the interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q    <= '0;
            status_q  <= '0;
            interrupt <= 1'b0;
        end else begin
            filt_q    <= filt;
            status_q  <= (status_q & ~csr.status_clr) | (evt & {NUM_PINS{armed}});
            interrupt <= |(status_q & csr.intr_enable);
        end
    end

    assign csr.filtered_data = filt;
    assign csr.status        = status_q;

endmodule

// File: tb/tb_gpio_ctrl_intr_engine.sv
// -----------------------------------------------------------------------------
// tb_gpio_ctrl_intr_engine
//   Directed scenarios plus randomised traffic for gpio_ctrl_intr_engine,
//   checked against a behavioural model of the bank.
// -----------------------------------------------------------------------------
module tb_gpio_ctrl_intr_engine;

    localparam int NP  = 32;
    localparam int SS  = 2;
    localparam int ARM = SS + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NP-1:0] gpio_in = '0;
    logic          intr;

    int n_checks = 0;
    int n_fail   = 0;

    gpio_ctrl_intr_engine_if #(.NUM_PINS(NP), .DEB_W(8), .PRESC_W(16)) csr_if ();

    gpio_ctrl_intr_engine #(
        .NUM_PINS    (NP),
        .SYNC_STAGES (SS),
        .DEB_W       (8),
        .PRESC_W     (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gpio_in   (gpio_in),
        .csr       (csr_if),
        .interrupt (intr)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Reference model. Prescaler and limit are only changed while in reset,
    // so the tick is the simple "every (P+1)th cycle since release".
    // The synchroniser is a delay line of SS samples; the filter flips once
    // a disagreement run has lasted limit+1 ticks.
    // ------------------------------------------------------------------
    logic [NP-1:0] m_pipe[$];
    logic [NP-1:0] m_f, m_fq, m_status, m_sync, m_fnx, m_ev;
    logic          m_intr, m_tk;
    int            m_k, m_p, m_lim;
    int            m_run[NP];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pipe = {};
            for (int s = 0; s < SS; s++) m_pipe.push_back('0);
            m_f = '0; m_fq = '0; m_status = '0; m_intr = 1'b0; m_k = 0;
            for (int i = 0; i < NP; i++) m_run[i] = 0;
        end else begin
            m_sync = m_pipe[0];
            m_p    = int'(csr_if.cfg_prescale);
            m_lim  = int'(csr_if.cfg_debounce_limit);
            m_tk   = ((m_k % (m_p + 1)) == m_p);
            m_fnx  = m_f;
            m_ev   = '0;
            for (int i = 0; i < NP; i++) begin
                if (!csr_if.cfg_debounce_en[i]) begin
                    m_fnx[i] = m_sync[i];
                    m_run[i] = 0;
                end else if (m_sync[i] == m_f[i]) begin
                    m_run[i] = 0;
                end else if (m_tk) begin
                    m_run[i]++;
                    if (m_run[i] > m_lim) begin
                        m_fnx[i] = m_sync[i];
                        m_run[i] = 0;
                    end
                end
                case (csr_if.cfg_mode[2*i +: 2])
                    2'b00:   m_ev[i] = m_f[i] && !m_fq[i];
                    2'b01:   m_ev[i] = !m_f[i] && m_fq[i];
                    2'b10:   m_ev[i] = m_f[i] != m_fq[i];
                    default: m_ev[i] = m_f[i];
                endcase
            end
            m_intr   = |(m_status & csr_if.intr_enable);
            m_status = (m_status & ~csr_if.status_clr) | (m_ev & {NP{m_k >= ARM}});
            m_fq     = m_f;
            m_f      = m_fnx;
            m_pipe.push_back(gpio_in);
            void'(m_pipe.pop_front());
            m_k++;
        end
    end

    // ------------------------------------------------------------ helpers
    task automatic set_defaults();
        csr_if.cfg_mode           = '0;
        csr_if.cfg_debounce_en    = '0;
        csr_if.cfg_debounce_limit = '0;
        csr_if.cfg_prescale       = '0;
        csr_if.intr_enable        = '0;
        csr_if.status_clr         = '0;
        gpio_in                   = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // -------------------------------------------------------------- tests
    task automatic test_reset();
        logic [NP-1:0] exp_f;
        set_defaults();
        gpio_in = '1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (csr_if.filtered_data !== '0 || csr_if.status !== '0 || intr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_reset got f=%h s=%h i=%b exp all 0",
                     csr_if.filtered_data, csr_if.status, intr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(negedge clk);
            exp_f = (e >= 3) ? '1 : '0;
            n_checks++;
            if (csr_if.filtered_data !== exp_f) begin
                n_fail++;
                $display("FAIL reset_filtered edge=%0d got=%h exp=%h", e, csr_if.filtered_data, exp_f);
            end
            n_checks++;
            if (csr_if.status !== '0 || intr !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_rise edge=%0d status=%h intr=%b exp 0/0", e, csr_if.status, intr);
            end
        end
    endtask

    task automatic test_rise_and_clear();
        logic [NP-1:0] exp_s;
        logic          exp_i;
        set_defaults();
        csr_if.intr_enable = 32'h20;
        apply_reset();
        repeat (8) @(negedge clk);
        gpio_in[5] = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            exp_s = (e >= 4) ? 32'h20 : 32'h0;
            exp_i = (e >= 5);
            n_checks++;
            if (csr_if.status !== exp_s || intr !== exp_i) begin
                n_fail++;
                $display("FAIL rise_latency edge=%0d status=%h intr=%b exp %h/%b",
                         e, csr_if.status, intr, exp_s, exp_i);
            end
        end
        csr_if.status_clr = 32'h20;
        @(negedge clk);
        csr_if.status_clr = '0;
        n_checks++;
        if (csr_if.status !== 32'h0 || intr !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_status status=%h intr=%b exp 0/1", csr_if.status, intr);
        end
        @(negedge clk);
        n_checks++;
        if (intr !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_intr got=%b exp=0", intr);
        end
    endtask

    task automatic test_debounce();
        set_defaults();
        csr_if.cfg_debounce_en[0]  = 1'b1;
        csr_if.cfg_debounce_limit  = 8'd3;
        csr_if.cfg_prescale        = 16'd1;
        csr_if.cfg_mode[1:0]       = 2'b10;
        apply_reset();
        repeat (10) @(negedge clk);
        gpio_in[0] = 1'b1;
        repeat (5) @(negedge clk);
        gpio_in[0] = 1'b0;
        for (int e = 0; e < 15; e++) begin
            @(negedge clk);
            n_checks++;
            if (csr_if.filtered_data[0] !== 1'b0 || csr_if.status[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch_dropped cyc=%0d f=%b s=%b exp 0/0",
                         e, csr_if.filtered_data[0], csr_if.status[0]);
            end
        end
        // Start the pulse so the synchronised edge lands just after a tick.
        while ((m_k % 2) != 0) @(negedge clk);
        gpio_in[0] = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            @(negedge clk);
            n_checks++;
            if (csr_if.filtered_data[0] !== (e >= 10) || csr_if.status[0] !== (e >= 11)) begin
                n_fail++;
                $display("FAIL debounce_rise edge=%0d f=%b s=%b exp %b/%b",
                         e, csr_if.filtered_data[0], csr_if.status[0], e >= 10, e >= 11);
            end
        end
        csr_if.status_clr[0] = 1'b1;
        @(negedge clk);
        csr_if.status_clr[0] = 1'b0;
        n_checks++;
        if (csr_if.status[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL debounce_clear got=%b exp=0", csr_if.status[0]);
        end
        repeat (8) @(negedge clk);
        gpio_in[0] = 1'b0;
        repeat (14) @(negedge clk);
        n_checks++;
        if (csr_if.filtered_data[0] !== 1'b0 || csr_if.status[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL debounce_fall f=%b s=%b exp 0/1", csr_if.filtered_data[0], csr_if.status[0]);
        end
        n_checks++;
        if (csr_if.status !== m_status) begin
            n_fail++;
            $display("FAIL debounce_model status=%h exp=%h", csr_if.status, m_status);
        end
    endtask

    task automatic test_level_high();
        set_defaults();
        csr_if.cfg_mode[5:4] = 2'b11;
        apply_reset();
        repeat (8) @(negedge clk);
        gpio_in[2] = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (csr_if.status !== 32'h4) begin
            n_fail++;
            $display("FAIL level_set got=%h exp=%h", csr_if.status, 32'h4);
        end
        csr_if.status_clr[2] = 1'b1;
        @(negedge clk);
        csr_if.status_clr[2] = 1'b0;
        for (int e = 0; e < 2; e++) begin
            n_checks++;
            if (csr_if.status[2] !== 1'b1) begin
                n_fail++;
                $display("FAIL level_clear_ignored cyc=%0d got=%b exp=1", e, csr_if.status[2]);
            end
            @(negedge clk);
        end
        gpio_in[2] = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (csr_if.status[2] !== 1'b1 || csr_if.filtered_data[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL level_low_held s=%b f=%b exp 1/0", csr_if.status[2], csr_if.filtered_data[2]);
        end
        csr_if.status_clr[2] = 1'b1;
        @(negedge clk);
        csr_if.status_clr[2] = 1'b0;
        n_checks++;
        if (csr_if.status !== 32'h0) begin
            n_fail++;
            $display("FAIL level_cleared got=%h exp=0", csr_if.status);
        end
    endtask

    task automatic test_clear_collision();
        set_defaults();
        csr_if.cfg_mode[3:2] = 2'b01;
        apply_reset();
        repeat (8) @(negedge clk);
        gpio_in[1] = 1'b1;
        repeat (6) @(negedge clk);
        gpio_in[1] = 1'b0;
        repeat (6) @(negedge clk);
        gpio_in[1] = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++;
        if (csr_if.status !== 32'h2) begin
            n_fail++;
            $display("FAIL fall_first got=%h exp=%h", csr_if.status, 32'h2);
        end
        gpio_in[1] = 1'b0;
        repeat (3) @(negedge clk);
        csr_if.status_clr[1] = 1'b1;
        @(negedge clk);
        csr_if.status_clr[1] = 1'b0;
        n_checks++;
        if (csr_if.status[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL set_beats_clear got=%b exp=1", csr_if.status[1]);
        end
        csr_if.status_clr[1] = 1'b1;
        @(negedge clk);
        csr_if.status_clr[1] = 1'b0;
        n_checks++;
        if (csr_if.status[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL plain_clear got=%b exp=0", csr_if.status[1]);
        end
    endtask

    task automatic test_mask_and_reset();
        set_defaults();
        apply_reset();
        repeat (8) @(negedge clk);
        gpio_in[31] = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++;
        if (csr_if.status !== 32'h8000_0000 || intr !== 1'b0) begin
            n_fail++;
            $display("FAIL masked_event status=%h intr=%b exp 80000000/0", csr_if.status, intr);
        end
        csr_if.intr_enable[31] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (intr !== 1'b1) begin
            n_fail++;
            $display("FAIL unmask_intr got=%b exp=1", intr);
        end
        csr_if.cfg_debounce_en[0] = 1'b1;
        csr_if.cfg_debounce_limit = 8'd200;
        gpio_in[0] = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (csr_if.filtered_data !== m_f || csr_if.filtered_data[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_count_filtered got=%h exp=%h", csr_if.filtered_data, m_f);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (csr_if.filtered_data !== '0 || csr_if.status !== '0 || intr !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset f=%h s=%h i=%b exp all 0", csr_if.filtered_data, csr_if.status, intr);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            set_defaults();
            csr_if.cfg_mode           = {$urandom, $urandom};
            csr_if.cfg_debounce_en    = $urandom;
            csr_if.cfg_debounce_limit = 8'($urandom_range(0, 3));
            csr_if.cfg_prescale       = 16'($urandom_range(0, 3));
            csr_if.intr_enable        = $urandom;
            gpio_in                   = $urandom;
            apply_reset();
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                n_checks++;
                if (csr_if.filtered_data !== m_f) begin
                    n_fail++;
                    $display("FAIL rand_filtered r=%0d c=%0d got=%h exp=%h", r, c, csr_if.filtered_data, m_f);
                end
                n_checks++;
                if (csr_if.status !== m_status) begin
                    n_fail++;
                    $display("FAIL rand_status r=%0d c=%0d got=%h exp=%h", r, c, csr_if.status, m_status);
                end
                n_checks++;
                if (intr !== m_intr) begin
                    n_fail++;
                    $display("FAIL rand_intr r=%0d c=%0d got=%b exp=%b", r, c, intr, m_intr);
                end
                gpio_in           = gpio_in ^ ($urandom & $urandom & $urandom);
                csr_if.status_clr = $urandom & $urandom & $urandom;
                if ((c % 50) == 49) begin
                    csr_if.cfg_debounce_en = csr_if.cfg_debounce_en ^ ($urandom & $urandom);
                    csr_if.intr_enable     = $urandom;
                end
            end
        end
    endtask

    initial begin
        set_defaults();
        test_reset();
        test_rise_and_clear();
        test_debounce();
        test_level_high();
        test_clear_collision();
        test_mask_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
